// File: rtl/wb_trace_if.sv
// Golden-entry stream and CPU writeback trace bundle for wb_trace_checker.
interface wb_trace_if;
  logic        gold_valid;
  logic        gold_ready;
  logic [31:0] gold_pc;
  logic [4:0]  gold_wnum;
  logic [31:0] gold_wdata;
  logic        gold_last;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  modport master (
    output gold_valid, gold_pc, gold_wnum, gold_wdata, gold_last,
    output debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    input  gold_ready
  );

  modport slave (
    input  gold_valid, gold_pc, gold_wnum, gold_wdata, gold_last,
    input  debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata,
    output gold_ready
  );
endinterface

// File: rtl/wb_trace_checker.sv
// Compares CPU writeback trace events against a FIFO of golden entries.
// Define TRACE_CHK_CONTINUE_EN to keep checking after a mismatch instead of failing at once.
//
// state  | meaning
// S_IDLE | after reset, no golden entry seen yet
// S_RUN  | golden entries queued, comparing trace events
// S_PASS | every entry through gold_last matched (terminal)
// S_FAIL | mismatch or underflow (terminal)
module wb_trace_checker #(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             resetn,
  wb_trace_if.slave        bus,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             err_underflow,
  output logic [31:0]      err_pc,
  output logic [31:0]      err_wdata,
  output logic [4:0]       err_wnum,
  output logic [CNT_W-1:0] match_cnt,
  output logic [15:0]      err_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    logic        last;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t        state;
  entry_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          alive, last_seen;
  logic          empty, full, active, push, pop, event_hit, hit;
  entry_t        head, incoming;
  logic [31:0]   lane_mask;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign active    = (state == S_IDLE) || (state == S_RUN);
  // alive keeps ready low until the first edge after reset is released
  assign bus.gold_ready = alive && active && !full && !last_seen;
  assign push      = bus.gold_valid && bus.gold_ready;
  assign event_hit = (bus.debug_wb_rf_wen != 4'd0) && (bus.debug_wb_rf_wnum != 5'd0);
  assign pop       = active && event_hit && !empty;

  assign incoming  = '{pc: bus.gold_pc, wnum: bus.gold_wnum, wdata: bus.gold_wdata, last: bus.gold_last};
  assign head      = mem[rd_ptr];
  assign lane_mask = {{8{bus.debug_wb_rf_wen[3]}}, {8{bus.debug_wb_rf_wen[2]}},
                      {8{bus.debug_wb_rf_wen[1]}}, {8{bus.debug_wb_rf_wen[0]}}};
  assign hit       = (head.pc == bus.debug_wb_pc) && (head.wnum == bus.debug_wb_rf_wnum) &&
                     (((head.wdata ^ bus.debug_wb_rf_wdata) & lane_mask) == 32'd0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= incoming;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= S_IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      alive         <= 1'b0;
      last_seen     <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      err_underflow <= 1'b0;
      err_pc        <= '0;
      err_wdata     <= '0;
      err_wnum      <= '0;
      match_cnt     <= '0;
      err_cnt       <= '0;
    end else begin
      alive <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (bus.gold_last) last_seen <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (!push && pop) count <= count - (AW+1)'(1);

      case (state)
        S_IDLE, S_RUN: begin
          if (event_hit && empty) begin
            state         <= S_FAIL;
            fail          <= 1'b1;
            done          <= 1'b1;
            err_underflow <= 1'b1;
            if (err_cnt == '0) begin
              err_pc    <= bus.debug_wb_pc;
              err_wnum  <= bus.debug_wb_rf_wnum;
              err_wdata <= bus.debug_wb_rf_wdata;
            end
          end else if (event_hit) begin
            state <= S_RUN;
            if (hit) begin
              if (match_cnt != '1) match_cnt <= match_cnt + CNT_W'(1);
              if (head.last) begin
                done <= 1'b1;
                if (err_cnt == '0) begin
                  state <= S_PASS;
                  pass  <= 1'b1;
                end else begin
                  state <= S_FAIL;
                  fail  <= 1'b1;
                end
              end
            end else begin
              if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
              // err_cnt still zero means this is the first failing event
              if (err_cnt == '0) begin
                err_pc    <= bus.debug_wb_pc;
                err_wnum  <= bus.debug_wb_rf_wnum;
                err_wdata <= bus.debug_wb_rf_wdata;
              end
`ifdef TRACE_CHK_CONTINUE_EN
              if (head.last) begin
                state <= S_FAIL;
                fail  <= 1'b1;
                done  <= 1'b1;
              end
`else
              state <= S_FAIL;
              fail  <= 1'b1;
              done  <= 1'b1;
`endif
            end
          end else if (!empty) begin
            state <= S_RUN;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_trace_checker.sv
// Randomized, model-checked bench for wb_trace_checker plus directed literal cases.
module tb_wb_trace_checker;
  localparam int FIFO_DEPTH = 16;
  localparam int CNT_W      = 32;

  logic clk = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  wb_trace_if bus();

  logic             done, pass, fail, err_underflow;
  logic [31:0]      err_pc, err_wdata;
  logic [4:0]       err_wnum;
  logic [CNT_W-1:0] match_cnt;
  logic [15:0]      err_cnt;

  wb_trace_checker #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .done(done), .pass(pass), .fail(fail), .err_underflow(err_underflow),
    .err_pc(err_pc), .err_wdata(err_wdata), .err_wnum(err_wnum),
    .match_cnt(match_cnt), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  wnum;
    logic [31:0] wdata;
    bit          last;
  } gold_t;

  gold_t       gold_q[$];
  bit          m_ready_en, m_done, m_pass, m_fail, m_uf, m_last_acc;
  logic [31:0] m_err_pc, m_err_wdata;
  logic [4:0]  m_err_wnum;
  longint      m_match;
  int          m_err;
  int          n_pass, n_total;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endfunction

  function automatic void m_clear();
    gold_q.delete();
    m_ready_en = 0; m_done = 0; m_pass = 0; m_fail = 0; m_uf = 0; m_last_acc = 0;
    m_err_pc = 0; m_err_wdata = 0; m_err_wnum = 0; m_match = 0; m_err = 0;
  endfunction

  function automatic logic [31:0] lanes(logic [3:0] wen);
    logic [31:0] m;
    m = 0;
    for (int b = 0; b < 4; b++) if (wen[b]) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic void m_latch(logic [31:0] pc, logic [4:0] wn, logic [31:0] wd);
    if (m_err == 0) begin m_err_pc = pc; m_err_wnum = wn; m_err_wdata = wd; end
  endfunction

  // One clock: check ready before the edge, advance the model, compare outputs after it.
  task automatic cycle(output bit acc);
    bit          exp_ready, ev, ok;
    gold_t       g, e;
    logic [31:0] epc, ewd;
    logic [3:0]  ewen;
    logic [4:0]  ewn;
    exp_ready = m_ready_en && !m_done && !m_last_acc && (gold_q.size() < FIFO_DEPTH);
    chk("gold_ready", 64'(bus.gold_ready), 64'(exp_ready));
    acc = bus.gold_valid && exp_ready;
    g.pc = bus.gold_pc; g.wnum = bus.gold_wnum; g.wdata = bus.gold_wdata; g.last = bus.gold_last;
    epc = bus.debug_wb_pc; ewen = bus.debug_wb_rf_wen; ewn = bus.debug_wb_rf_wnum; ewd = bus.debug_wb_rf_wdata;
    ev = (ewen != 0) && (ewn != 0);
    @(posedge clk);
    m_ready_en = 1;
    if (!m_done && ev) begin
      if (gold_q.size() == 0) begin
        m_latch(epc, ewn, ewd);
        m_done = 1; m_fail = 1; m_uf = 1;
      end else begin
        e = gold_q.pop_front();
        ok = (e.pc == epc) && (e.wnum == ewn);
        for (int b = 0; b < 4; b++)
          if (ewen[b] && (e.wdata[8*b +: 8] != ewd[8*b +: 8])) ok = 0;
        if (ok) begin
          if (m_match < 64'hFFFF_FFFF) m_match++;
          if (e.last) begin
            m_done = 1;
            if (m_err == 0) m_pass = 1; else m_fail = 1;
          end
        end else begin
          m_latch(epc, ewn, ewd);
          if (m_err < 65535) m_err++;
`ifdef TRACE_CHK_CONTINUE_EN
          if (e.last) begin m_done = 1; m_fail = 1; end
`else
          m_done = 1; m_fail = 1;
`endif
        end
      end
    end
    if (acc) begin
      gold_q.push_back(g);
      if (g.last) m_last_acc = 1;
    end
    #1;
    chk("done", 64'(done), 64'(m_done));
    chk("pass", 64'(pass), 64'(m_pass));
    chk("fail", 64'(fail), 64'(m_fail));
    chk("err_underflow", 64'(err_underflow), 64'(m_uf));
    chk("err_pc", 64'(err_pc), 64'(m_err_pc));
    chk("err_wnum", 64'(err_wnum), 64'(m_err_wnum));
    chk("err_wdata", 64'(err_wdata), 64'(m_err_wdata));
    chk("match_cnt", 64'(match_cnt), 64'(m_match));
    chk("err_cnt", 64'(err_cnt), 64'(m_err));
  endtask

  task automatic drive(bit gv, logic [31:0] gpc, logic [4:0] gwn, logic [31:0] gwd, bit gl,
                       logic [3:0] wen, logic [31:0] dpc, logic [4:0] dwn, logic [31:0] dwd,
                       output bit acc);
    bus.gold_valid = gv; bus.gold_pc = gpc; bus.gold_wnum = gwn; bus.gold_wdata = gwd; bus.gold_last = gl;
    bus.debug_wb_rf_wen = wen; bus.debug_wb_pc = dpc; bus.debug_wb_rf_wnum = dwn; bus.debug_wb_rf_wdata = dwd;
    cycle(acc);
  endtask

  task automatic push(logic [31:0] pc, logic [4:0] wn, logic [31:0] wd, bit last);
    bit acc;
    drive(1, pc, wn, wd, last, 4'd0, 32'd0, 5'd0, 32'd0, acc);
  endtask

  task automatic event_only(logic [3:0] wen, logic [31:0] pc, logic [4:0] wn, logic [31:0] wd);
    bit acc;
    drive(0, 32'd0, 5'd0, 32'd0, 0, wen, pc, wn, wd, acc);
  endtask

  task automatic idle();
    bit acc;
    drive(0, 32'd0, 5'd0, 32'd0, 0, 4'd0, 32'd0, 5'd0, 32'd0, acc);
  endtask

  // Called between edges; asserts reset away from any clock edge and checks outputs at once.
  task automatic apply_reset();
    bit acc;
    #3;
    resetn = 1'b0;
    #1;
    m_clear();
    chk("rst_gold_ready", 64'(bus.gold_ready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_pass", 64'(pass), 64'd0);
    chk("rst_fail", 64'(fail), 64'd0);
    chk("rst_underflow", 64'(err_underflow), 64'd0);
    chk("rst_err_pc", 64'(err_pc), 64'd0);
    chk("rst_err_wnum", 64'(err_wnum), 64'd0);
    chk("rst_err_wdata", 64'(err_wdata), 64'd0);
    chk("rst_match_cnt", 64'(match_cnt), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    bus.gold_valid = 0; bus.debug_wb_rf_wen = 0; bus.debug_wb_rf_wnum = 0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle();
    chk("ready_after_reset", 64'(bus.gold_ready), 64'd1);
  endtask

  task automatic random_round();
    int          nent, pushed, tail, k;
    bit          gv, acc;
    logic [31:0] gpc, gwd, dpc, dwd, m;
    logic [4:0]  gwn, dwn;
    logic [3:0]  wen;
    gold_t       g;
    apply_reset();
    nent = $urandom_range(1, 2 * FIFO_DEPTH);
    pushed = 0;
    tail = 0;
    for (int c = 0; c < 300; c++) begin
      gv  = (pushed < nent) && ($urandom_range(0, 9) < 6);
      gpc = 32'hBFC0_0000 + 32'($urandom_range(0, 1023)) * 4;
      gwn = 5'($urandom_range(1, 31));
      gwd = $urandom;
      wen = 0; dpc = 0; dwn = 0; dwd = 0;
      k = $urandom_range(0, 99);
      if (k < 45 && gold_q.size() > 0) begin
        g   = gold_q[0];
        wen = 4'($urandom_range(1, 15));
        m   = lanes(wen);
        dpc = g.pc; dwn = g.wnum;
        dwd = (g.wdata & m) | ($urandom & ~m);
        if ($urandom_range(0, 99) < 12) begin
          case ($urandom_range(0, 2))
            0: dpc = dpc ^ 32'd4;
            1: dwn = (dwn == 5'd31) ? 5'd1 : dwn + 5'd1;
            default: dwd = dwd ^ m;
          endcase
        end
      end else if (k < 47) begin
        wen = 4'($urandom_range(1, 15)); dpc = $urandom; dwn = 5'($urandom_range(1, 31)); dwd = $urandom;
      end else if (k < 57) begin
        if (k < 52) begin wen = 4'($urandom_range(1, 15)); dwn = 0; end
        else begin wen = 0; dwn = 5'($urandom_range(1, 31)); end
        dpc = $urandom; dwd = $urandom;
      end
      drive(gv, gpc, gwn, gwd, pushed == nent - 1, wen, dpc, dwn, dwd, acc);
      if (acc) pushed++;
      if (m_done) tail++;
      if (tail > 3) break;
    end
  endtask

  initial begin
    bit acc;
    n_pass = 0; n_total = 0;
    m_clear();
    bus.gold_valid = 0; bus.gold_pc = 0; bus.gold_wnum = 0; bus.gold_wdata = 0; bus.gold_last = 0;
    bus.debug_wb_pc = 0; bus.debug_wb_rf_wen = 0; bus.debug_wb_rf_wnum = 0; bus.debug_wb_rf_wdata = 0;

    // three-entry trace replayed exactly
    apply_reset();
    push(32'hBFC0_0000, 5'd1, 32'h1111_1111, 0);
    push(32'hBFC0_0004, 5'd2, 32'h2222_2222, 0);
    push(32'hBFC0_0008, 5'd3, 32'h3333_3333, 1);
    event_only(4'hF, 32'hBFC0_0000, 5'd1, 32'h1111_1111);
    event_only(4'hF, 32'hBFC0_0004, 5'd2, 32'h2222_2222);
    chk("s3_pass_early", 64'(pass), 64'd0);
    event_only(4'hF, 32'hBFC0_0008, 5'd3, 32'h3333_3333);
    chk("s3_pass", 64'(pass), 64'd1);
    chk("s3_done", 64'(done), 64'd1);
    chk("s3_match_cnt", 64'(match_cnt), 64'd3);
    chk("s3_ready_after_last", 64'(bus.gold_ready), 64'd0);

    // byte-lane masking
    apply_reset();
    push(32'h0000_1000, 5'd4, 32'h1234_5678, 0);
    push(32'h0000_1004, 5'd5, 32'h1234_5678, 1);
    event_only(4'b0001, 32'h0000_1000, 5'd4, 32'hFFFF_FF78);
    chk("lane_match_cnt", 64'(match_cnt), 64'd1);
    chk("lane_no_fail", 64'(fail), 64'd0);
    event_only(4'b0011, 32'h0000_1004, 5'd5, 32'hFFFF_FF78);
    chk("lane_fail", 64'(fail), 64'd1);
    chk("lane_err_cnt", 64'(err_cnt), 64'd1);
    chk("lane_err_wdata", 64'(err_wdata), 64'hFFFF_FF78);
    chk("lane_err_pc", 64'(err_pc), 64'h0000_1004);

    // ignored cycles, then underflow
    apply_reset();
    event_only(4'hF, 32'hDEAD_0000, 5'd0, 32'h1);
    event_only(4'h0, 32'hDEAD_0004, 5'd3, 32'h2);
    chk("ign_done", 64'(done), 64'd0);
    event_only(4'b0001, 32'h1234_5678, 5'd7, 32'hCAFE_0001);
    chk("uf_fail", 64'(fail), 64'd1);
    chk("uf_flag", 64'(err_underflow), 64'd1);
    chk("uf_err_pc", 64'(err_pc), 64'h1234_5678);
    chk("uf_err_wnum", 64'(err_wnum), 64'd7);

    // full FIFO, simultaneous event and offer
    apply_reset();
    for (int i = 0; i < FIFO_DEPTH; i++)
      push(32'h8000_0000 + 32'(i) * 4, 5'(i % 31 + 1), 32'h0101_0101 * 32'(i), 0);
    chk("full_ready", 64'(bus.gold_ready), 64'd0);
    drive(1, 32'h9000_0000, 5'd9, 32'h9999_9999, 1, 4'hF, 32'h8000_0000, 5'd1, 32'h0, acc);
    chk("full_pop_only_match", 64'(match_cnt), 64'd1);
    chk("full_ready_after_pop", 64'(bus.gold_ready), 64'd1);
    drive(1, 32'h9000_0000, 5'd9, 32'h9999_9999, 1, 4'h0, 32'h0, 5'd0, 32'h0, acc);
    for (int i = 1; i < FIFO_DEPTH; i++)
      event_only(4'hF, 32'h8000_0000 + 32'(i) * 4, 5'(i % 31 + 1), 32'h0101_0101 * 32'(i));
    event_only(4'hF, 32'h9000_0000, 5'd9, 32'h9999_9999);
    chk("full_pass", 64'(pass), 64'd1);
    chk("full_match_cnt", 64'(match_cnt), 64'(FIFO_DEPTH + 1));

    // mismatch on entry 2 of 4
    apply_reset();
    for (int i = 0; i < 4; i++) push(32'hA000_0000 + 32'(i) * 4, 5'(i + 1), 32'h100 + 32'(i), i == 3);
    event_only(4'hF, 32'hA000_0000, 5'd1, 32'h100);
    event_only(4'hF, 32'hA000_0004, 5'd2, 32'h555);
    chk("mm2_err_cnt", 64'(err_cnt), 64'd1);
`ifdef TRACE_CHK_CONTINUE_EN
    chk("mm2_fail_early", 64'(fail), 64'd0);
`else
    chk("mm2_fail_early", 64'(fail), 64'd1);
`endif
    event_only(4'hF, 32'hA000_0008, 5'd3, 32'h102);
    event_only(4'hF, 32'hA000_000C, 5'd4, 32'h103);
    chk("mm2_fail", 64'(fail), 64'd1);
    chk("mm2_err_cnt_end", 64'(err_cnt), 64'd1);
    chk("mm2_err_pc", 64'(err_pc), 64'hA000_0004);
`ifdef TRACE_CHK_CONTINUE_EN
    chk("mm2_match_cnt", 64'(match_cnt), 64'd3);
`else
    chk("mm2_match_cnt", 64'(match_cnt), 64'd1);
`endif

    // reset mid-run with entries queued, then a fresh one-entry trace
    apply_reset();
    for (int i = 0; i < 5; i++) push(32'hC000_0000 + 32'(i) * 4, 5'd6, 32'h77 + 32'(i), 0);
    event_only(4'hF, 32'hC000_0000, 5'd6, 32'h77);
    chk("mid_match_cnt", 64'(match_cnt), 64'd1);
    apply_reset();
    push(32'hD000_0000, 5'd8, 32'hABCD_EF01, 1);
    event_only(4'hF, 32'hD000_0000, 5'd8, 32'hABCD_EF01);
    chk("fresh_pass", 64'(pass), 64'd1);
    chk("fresh_match_cnt", 64'(match_cnt), 64'd1);

    for (int r = 0; r < 24; r++) random_round();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
